// File: rtl/issue_pair_pkg.sv
// Shared types and constants for the dual-issue pairing stage.
package issue_pair_pkg;

    localparam int ALU_OP_WIDTH  = 4;
    localparam int REG_IDX_WIDTH = 5;

    // Opcodes at or above ALU_MUL use the single mul/div unit.
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL = 4'd8;

    localparam logic ISSUE_ST_EMPTY = 1'b0;
    localparam logic ISSUE_ST_HOLD  = 1'b1;

    typedef enum logic {
        ST_EMPTY = ISSUE_ST_EMPTY,
        ST_HOLD  = ISSUE_ST_HOLD
    } issue_state_e;

    typedef struct packed {
        logic [ALU_OP_WIDTH-1:0]  aluop;
        logic [31:0]              inst;
        logic [REG_IDX_WIDTH-1:0] rd;
        logic [REG_IDX_WIDTH-1:0] rs1;
        logic [REG_IDX_WIDTH-1:0] rs2;
        logic                     regwr;
        logic                     ldst;
        logic                     branch;
    } slot_t;

endpackage

// File: rtl/issue_pair_if.sv
// Decode-to-issue pair handshake plus the registered EX issue packet.
interface issue_pair_if
    import issue_pair_pkg::*;
#(
    parameter int PERF_W = 16
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [ALU_OP_WIDTH-1:0]  in_aluop_0,  in_aluop_1;
    logic [31:0]              in_inst_0,   in_inst_1;
    logic [REG_IDX_WIDTH-1:0] in_rd_0,     in_rd_1;
    logic [REG_IDX_WIDTH-1:0] in_rs1_0,    in_rs1_1;
    logic [REG_IDX_WIDTH-1:0] in_rs2_0,    in_rs2_1;
    logic                     in_regwr_0,  in_regwr_1;
    logic                     in_ldst_0,   in_ldst_1;
    logic                     in_branch_0, in_branch_1;
    logic                     ex_stall;
    logic                     flush;

    logic                     out_valid_0,  out_valid_1;
    logic [ALU_OP_WIDTH-1:0]  out_aluop_0,  out_aluop_1;
    logic [31:0]              out_inst_0,   out_inst_1;
    logic [REG_IDX_WIDTH-1:0] out_rd_0,     out_rd_1;
    logic [REG_IDX_WIDTH-1:0] out_rs1_0,    out_rs1_1;
    logic [REG_IDX_WIDTH-1:0] out_rs2_0,    out_rs2_1;
    logic                     out_regwr_0,  out_regwr_1;
    logic                     out_ldst_0,   out_ldst_1;
    logic                     out_branch_0, out_branch_1;
    logic [PERF_W-1:0]        perf_split_cnt;

    modport master (
        output in_valid, in_aluop_0, in_aluop_1, in_inst_0, in_inst_1,
               in_rd_0, in_rd_1, in_rs1_0, in_rs1_1, in_rs2_0, in_rs2_1,
               in_regwr_0, in_regwr_1, in_ldst_0, in_ldst_1,
               in_branch_0, in_branch_1, ex_stall, flush,
        input  in_ready, out_valid_0, out_valid_1, out_aluop_0, out_aluop_1,
               out_inst_0, out_inst_1, out_rd_0, out_rd_1, out_rs1_0, out_rs1_1,
               out_rs2_0, out_rs2_1, out_regwr_0, out_regwr_1,
               out_ldst_0, out_ldst_1, out_branch_0, out_branch_1, perf_split_cnt
    );

    modport slave (
        input  in_valid, in_aluop_0, in_aluop_1, in_inst_0, in_inst_1,
               in_rd_0, in_rd_1, in_rs1_0, in_rs1_1, in_rs2_0, in_rs2_1,
               in_regwr_0, in_regwr_1, in_ldst_0, in_ldst_1,
               in_branch_0, in_branch_1, ex_stall, flush,
        output in_ready, out_valid_0, out_valid_1, out_aluop_0, out_aluop_1,
               out_inst_0, out_inst_1, out_rd_0, out_rd_1, out_rs1_0, out_rs1_1,
               out_rs2_0, out_rs2_1, out_regwr_0, out_regwr_1,
               out_ldst_0, out_ldst_1, out_branch_0, out_branch_1, perf_split_cnt
    );

endinterface

// File: rtl/issue_conflict.sv
// Combinational pairing-hazard check: high when the two instructions must not issue together.
module issue_conflict
    import issue_pair_pkg::*;
(
    input  logic [ALU_OP_WIDTH-1:0]  aluop_0_i,
    input  logic [ALU_OP_WIDTH-1:0]  aluop_1_i,
    input  logic [REG_IDX_WIDTH-1:0] rd_0_i,
    input  logic [REG_IDX_WIDTH-1:0] rd_1_i,
    input  logic [REG_IDX_WIDTH-1:0] rs1_1_i,
    input  logic [REG_IDX_WIDTH-1:0] rs2_1_i,
    input  logic                     regwr_0_i,
    input  logic                     regwr_1_i,
    input  logic                     ldst_0_i,
    input  logic                     ldst_1_i,
    input  logic                     branch_0_i,
    output logic                     conflict_o
);

    logic raw, waw, muldiv, mem_ctrl;

    // x0 is never a real dependency, so it cannot cause RAW or WAW.
    assign raw      = regwr_0_i && (rd_0_i != '0) && ((rd_0_i == rs1_1_i) || (rd_0_i == rs2_1_i));
    assign waw      = regwr_0_i && regwr_1_i && (rd_0_i == rd_1_i) && (rd_0_i != '0);
    assign muldiv   = (aluop_0_i >= ALU_MUL) && (aluop_1_i >= ALU_MUL);
    assign mem_ctrl = ldst_0_i || branch_0_i || (ldst_0_i && ldst_1_i);

    assign conflict_o = mem_ctrl || raw || waw || muldiv;

endmodule

// File: rtl/issue_pair.sv
// ID/EX dual-issue pairing stage: issues legal pairs together, splits hazardous ones over two cycles.
module issue_pair
    import issue_pair_pkg::*;
#(
    parameter int PERF_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    issue_pair_if.slave  bus
);

    issue_state_e      state_q;
    slot_t             slot0_q, slot1_q, hold_q;
    logic              valid0_q, valid1_q;
    logic [PERF_W-1:0] perf_q;
    slot_t             in_0, in_1;
    logic              conflict;
    logic              accept;

    assign in_0 = {bus.in_aluop_0, bus.in_inst_0, bus.in_rd_0, bus.in_rs1_0, bus.in_rs2_0,
                   bus.in_regwr_0, bus.in_ldst_0, bus.in_branch_0};
    assign in_1 = {bus.in_aluop_1, bus.in_inst_1, bus.in_rd_1, bus.in_rs1_1, bus.in_rs2_1,
                   bus.in_regwr_1, bus.in_ldst_1, bus.in_branch_1};

    issue_conflict u_conflict (
        .aluop_0_i  (in_0.aluop),
        .aluop_1_i  (in_1.aluop),
        .rd_0_i     (in_0.rd),
        .rd_1_i     (in_1.rd),
        .rs1_1_i    (in_1.rs1),
        .rs2_1_i    (in_1.rs2),
        .regwr_0_i  (in_0.regwr),
        .regwr_1_i  (in_1.regwr),
        .ldst_0_i   (in_0.ldst),
        .ldst_1_i   (in_1.ldst),
        .branch_0_i (in_0.branch),
        .conflict_o (conflict)
    );

    assign bus.in_ready = (state_q == ST_EMPTY) && !bus.ex_stall && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            slot0_q  <= '0;
            slot1_q  <= '0;
            hold_q   <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            perf_q   <= '0;
        end else if (bus.flush) begin
            // Returning to EMPTY is what invalidates the hold buffer.
            state_q  <= ST_EMPTY;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
        end else if (!bus.ex_stall) begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        slot0_q  <= in_0;
                        valid0_q <= 1'b1;
                        if (conflict) begin
                            valid1_q <= 1'b0;
                            hold_q   <= in_1;
                            state_q  <= ST_HOLD;
                            if (perf_q != '1) begin
                                perf_q <= perf_q + 1'b1;
                            end
                        end else begin
                            slot1_q  <= in_1;
                            valid1_q <= 1'b1;
                        end
                    end else begin
                        valid0_q <= 1'b0;
                        valid1_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    slot0_q  <= hold_q;
                    valid0_q <= 1'b1;
                    valid1_q <= 1'b0;
                    state_q  <= ST_EMPTY;
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign bus.out_valid_0    = valid0_q;
    assign bus.out_valid_1    = valid1_q;
    assign bus.out_aluop_0    = slot0_q.aluop;
    assign bus.out_aluop_1    = slot1_q.aluop;
    assign bus.out_inst_0     = slot0_q.inst;
    assign bus.out_inst_1     = slot1_q.inst;
    assign bus.out_rd_0       = slot0_q.rd;
    assign bus.out_rd_1       = slot1_q.rd;
    assign bus.out_rs1_0      = slot0_q.rs1;
    assign bus.out_rs1_1      = slot1_q.rs1;
    assign bus.out_rs2_0      = slot0_q.rs2;
    assign bus.out_rs2_1      = slot1_q.rs2;
    assign bus.out_regwr_0    = slot0_q.regwr;
    assign bus.out_regwr_1    = slot1_q.regwr;
    assign bus.out_ldst_0     = slot0_q.ldst;
    assign bus.out_ldst_1     = slot1_q.ldst;
    assign bus.out_branch_0   = slot0_q.branch;
    assign bus.out_branch_1   = slot1_q.branch;
    assign bus.perf_split_cnt = perf_q;

endmodule

// File: tb/tb_issue_pair.sv
// Scoreboard bench for issue_pair: directed pairs push expected packets, a monitor checks what EX consumes.
module tb_issue_pair;
    import issue_pair_pkg::*;

    typedef struct {
        logic  v1;
        slot_t s0;
        slot_t s1;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   exp_perf = 0;
    exp_t exp_q[$];

    issue_pair_if #(.PERF_W(4)) bus ();

    issue_pair #(.PERF_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic slot_t mk(input logic [3:0] op, input logic [31:0] inst,
                                 input int rd, input int rs1, input int rs2,
                                 input logic wr, input logic ls, input logic br);
        slot_t s;
        s.aluop  = op;
        s.inst   = inst;
        s.rd     = rd[4:0];
        s.rs1    = rs1[4:0];
        s.rs2    = rs2[4:0];
        s.regwr  = wr;
        s.ldst   = ls;
        s.branch = br;
        return s;
    endfunction

    function automatic slot_t out0();
        return {bus.out_aluop_0, bus.out_inst_0, bus.out_rd_0, bus.out_rs1_0, bus.out_rs2_0,
                bus.out_regwr_0, bus.out_ldst_0, bus.out_branch_0};
    endfunction

    function automatic slot_t out1();
        return {bus.out_aluop_1, bus.out_inst_1, bus.out_rd_1, bus.out_rs1_1, bus.out_rs2_1,
                bus.out_regwr_1, bus.out_ldst_1, bus.out_branch_1};
    endfunction

    // EX consumes the packet on any edge without stall or flush.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid_0 && !bus.ex_stall && !bus.flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {32'h0, bus.out_inst_0}, 64'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("issue: inst0=%h v1=%0d inst1=%h", bus.out_inst_0, bus.out_valid_1, bus.out_inst_1);
                chk("valid1", {63'h0, bus.out_valid_1}, {63'h0, e.v1});
                chk("slot0", {10'h0, out0()}, {10'h0, e.s0});
                if (e.v1) chk("slot1", {10'h0, out1()}, {10'h0, e.s1});
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_in(input slot_t a, input slot_t b);
        {bus.in_aluop_0, bus.in_inst_0, bus.in_rd_0, bus.in_rs1_0, bus.in_rs2_0,
         bus.in_regwr_0, bus.in_ldst_0, bus.in_branch_0} = a;
        {bus.in_aluop_1, bus.in_inst_1, bus.in_rd_1, bus.in_rs1_1, bus.in_rs2_1,
         bus.in_regwr_1, bus.in_ldst_1, bus.in_branch_1} = b;
    endtask

    // Offer a pair until accepted; split is the hand-computed pairing decision.
    task automatic issue(input slot_t a, input slot_t b, input bit split, input bit push, output int waits);
        bit acc = 1'b0;
        exp_t e;
        waits = 0;
        set_in(a, b);
        bus.in_valid = 1'b1;
        while (!acc && waits < 20) begin
            #1 acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 64'h0, 64'h1);
        end else begin
            if (split && exp_perf < 15) exp_perf++;
            if (push) begin
                e.v1 = !split; e.s0 = a; e.s1 = b;
                exp_q.push_back(e);
                if (split) begin
                    e.v1 = 1'b0; e.s0 = b; e.s1 = '0;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        slot_t ld, add;
        bus.in_valid = 1'b0;
        bus.ex_stall = 1'b0;
        bus.flush    = 1'b0;
        set_in('0, '0);

        // Reset state
        #12;
        chk("rst_valid0", {63'h0, bus.out_valid_0}, 64'h0);
        chk("rst_valid1", {63'h0, bus.out_valid_1}, 64'h0);
        chk("rst_slot0", {10'h0, out0()}, 64'h0);
        chk("rst_slot1", {10'h0, out1()}, 64'h0);
        chk("rst_perf", {60'h0, bus.perf_split_cnt}, 64'h0);
        chk("rst_ready", {63'h0, bus.in_ready}, 64'h1);
        rst_n = 1'b1;
        idle(2);

        // Two independent ADDs issue together
        issue(mk(ALU_ADD, 32'hA001, 3, 1, 2, 1, 0, 0), mk(ALU_ADD, 32'hA002, 4, 5, 6, 1, 0, 0), 0, 1, w);
        chk("add_pair_v1_now", {63'h0, bus.out_valid_1}, 64'h1);
        chk("add_pair_perf", {60'h0, bus.perf_split_cnt}, 64'h0);
        // Back-to-back non-conflicting pairs: full throughput
        issue(mk(ALU_ADD, 32'hA003, 10, 1, 2, 1, 0, 0), mk(ALU_ADD, 32'hA004, 11, 1, 2, 1, 0, 0), 0, 1, w);
        chk("b2b_wait", w, 0);

        // Load in slot 0 forces a split
        issue(mk(ALU_ADD, 32'hB001, 5, 1, 0, 1, 1, 0), mk(ALU_ADD, 32'hB002, 6, 2, 3, 1, 0, 0), 1, 1, w);
        chk("ld_ready_hold", {63'h0, bus.in_ready}, 64'h0);
        chk("ld_v1_zero", {63'h0, bus.out_valid_1}, 64'h0);
        chk("ld_perf", {60'h0, bus.perf_split_cnt}, 64'(exp_perf));
        // RAW through rs1 right after a split: one bubble
        issue(mk(ALU_ADD, 32'hC001, 7, 1, 2, 1, 0, 0), mk(ALU_ADD, 32'hC002, 8, 7, 2, 1, 0, 0), 1, 1, w);
        chk("split_bubble", w, 1);
        // Same shape on x0 is not a hazard
        issue(mk(ALU_ADD, 32'hC003, 0, 1, 2, 1, 0, 0), mk(ALU_ADD, 32'hC004, 8, 0, 0, 1, 0, 0), 0, 1, w);
        // RAW through rs2, WAW, double mul/div, slot-0 branch all split
        issue(mk(ALU_ADD, 32'hC005, 9, 1, 2, 1, 0, 0), mk(ALU_ADD, 32'hC006, 12, 3, 9, 1, 0, 0), 1, 1, w);
        issue(mk(ALU_ADD, 32'hD001, 9, 1, 2, 1, 0, 0), mk(ALU_ADD, 32'hD002, 9, 3, 4, 1, 0, 0), 1, 1, w);
        issue(mk(ALU_MUL, 32'hD003, 13, 1, 2, 1, 0, 0), mk(4'd9, 32'hD004, 14, 3, 4, 1, 0, 0), 1, 1, w);
        issue(mk(ALU_ADD, 32'hD005, 0, 1, 2, 0, 0, 1), mk(ALU_ADD, 32'hD006, 15, 3, 4, 1, 0, 0), 1, 1, w);
        // Slot-1 load, one mul, WAW on x0: all legal pairs
        issue(mk(ALU_ADD, 32'hD007, 16, 1, 2, 1, 0, 0), mk(ALU_ADD, 32'hD008, 17, 3, 4, 1, 1, 0), 0, 1, w);
        issue(mk(ALU_MUL, 32'hD009, 18, 1, 2, 1, 0, 0), mk(ALU_ADD, 32'hD00A, 19, 3, 4, 1, 0, 0), 0, 1, w);
        issue(mk(ALU_ADD, 32'hD00B, 0, 1, 2, 1, 0, 0), mk(ALU_ADD, 32'hD00C, 0, 3, 4, 1, 0, 0), 0, 1, w);
        idle(3);
        chk("perf_after_mix", {60'h0, bus.perf_split_cnt}, 64'(exp_perf));

        // Stall for three cycles while holding
        ld  = mk(ALU_ADD, 32'hE001, 20, 1, 0, 1, 1, 0);
        add = mk(ALU_ADD, 32'hE002, 21, 2, 3, 1, 0, 0);
        issue(ld, add, 1, 1, w);
        bus.ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_v0", {63'h0, bus.out_valid_0}, 64'h1);
            chk("stall_inst0", {32'h0, bus.out_inst_0}, {32'h0, ld.inst});
            chk("stall_v1", {63'h0, bus.out_valid_1}, 64'h0);
            chk("stall_ready", {63'h0, bus.in_ready}, 64'h0);
        end
        bus.ex_stall = 1'b0;
        idle(4);
        chk("stall_drain", exp_q.size(), 0);

        // Flush while holding discards the held instruction
        issue(mk(ALU_ADD, 32'hF001, 22, 1, 0, 1, 1, 0), mk(ALU_ADD, 32'hF002, 23, 2, 3, 1, 0, 0), 1, 0, w);
        bus.flush = 1'b1;
        #1;
        chk("flush_ready_low", {63'h0, bus.in_ready}, 64'h0);
        cycle();
        bus.flush = 1'b0;
        #1;
        chk("flush_v0", {63'h0, bus.out_valid_0}, 64'h0);
        chk("flush_v1", {63'h0, bus.out_valid_1}, 64'h0);
        chk("flush_ready", {63'h0, bus.in_ready}, 64'h1);
        issue(mk(ALU_ADD, 32'hF003, 24, 1, 2, 1, 0, 0), mk(ALU_ADD, 32'hF004, 25, 3, 4, 1, 0, 0), 0, 1, w);
        chk("flush_next_wait", w, 0);
        idle(2);

        // Asynchronous reset mid-HOLD loses the held instruction
        issue(mk(ALU_ADD, 32'h1001, 26, 1, 0, 1, 1, 0), mk(ALU_ADD, 32'h1002, 27, 2, 3, 1, 0, 0), 1, 0, w);
        #1 rst_n = 1'b0;
        #1;
        exp_perf = 0;
        chk("arst_v0", {63'h0, bus.out_valid_0}, 64'h0);
        chk("arst_slot0", {10'h0, out0()}, 64'h0);
        chk("arst_perf", {60'h0, bus.perf_split_cnt}, 64'h0);
        #2 rst_n = 1'b1;
        idle(4);
        chk("arst_ready", {63'h0, bus.in_ready}, 64'h1);

        // Saturation: 2^4 + 5 splits
        for (int i = 0; i < 21; i++) begin
            issue(mk(ALU_ADD, 32'h2000 + i, 1, 2, 3, 1, 1, 0), mk(ALU_ADD, 32'h3000 + i, 4, 5, 6, 1, 0, 0), 1, 1, w);
            if (i == 14) chk("perf_at_15", {60'h0, bus.perf_split_cnt}, 64'd15);
        end
        idle(4);
        chk("perf_saturated", {60'h0, bus.perf_split_cnt}, 64'd15);
        chk("perf_model", {60'h0, bus.perf_split_cnt}, 64'(exp_perf));
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_pair.md
# issue_pair

Dual-issue pairing stage at the ID/EX boundary: accepts one decoded instruction pair per handshake and decides whether both may issue together. It emits registered slot-0/slot-1 issue packets to EX. It is the producer end of the EX-side slot squash: a slot-0 load/store or branch, and every other pairing hazard, is split here so EX receives only legal pairs. A split pair issues over two cycles, with the second instruction held in a one-entry buffer.

## Interface
Parameters:
- `PERF_W`, default 16: width of the saturating split counter.

Ports:
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: decode presents a pair.
- `in_ready`, output, 1: pair accepted when `in_valid && in_ready`.
- `in_aluop_0` / `in_aluop_1`, input, `ALU_OP_WIDTH: ALU opcodes; values >= `ALU_MUL are mul/div.
- `in_inst_0` / `in_inst_1`, input, 32: raw instruction payloads.
- `in_rd_0` / `in_rd_1`, `in_rs1_0` / `in_rs1_1`, `in_rs2_0` / `in_rs2_1`, input, 5 each: register indices.
- `in_regwr_0` / `in_regwr_1`, `in_ldst_0` / `in_ldst_1`, `in_branch_0` / `in_branch_1`, input, 1 each: decode flags.
- `ex_stall`, input, 1: EX cannot take a new packet; all outputs hold.
- `flush`, input, 1: redirect; discard everything.
- `out_valid_0` / `out_valid_1`, output, 1: slot valid.
- `out_aluop_0` / `out_aluop_1`, `out_inst_0` / `out_inst_1`, `out_rd_0` / `out_rd_1`, `out_rs1_0` / `out_rs1_1`, `out_rs2_0` / `out_rs2_1`, `out_regwr_0` / `out_regwr_1`, `out_ldst_0` / `out_ldst_1`, `out_branch_0` / `out_branch_1`, output: registered issue packet.
- `perf_split_cnt`, output, `PERF_W`: number of split pairs, saturating.

## Operation
- A pair is **conflicting** when any of the following holds:
  - `in_ldst_0` or `in_branch_0` is set;
  - both `in_ldst` flags are set;
  - RAW: `in_regwr_0` is set, `in_rd_0` != 0, and `in_rd_0` equals `in_rs1_1` or `in_rs2_1`;
  - WAW: both `in_regwr` flags are set, `in_rd_0` equals `in_rd_1`, and it is != 0;
  - both ALU opcodes are >= `ALU_MUL`.
- FSM state `EMPTY`:
  - `in_ready` = !`ex_stall` && !`flush`.
  - On accept with no conflict: load both slots, set `out_valid_0` = `out_valid_1` = 1, stay in `EMPTY`.
  - On accept with a conflict: load slot 0 only, set `out_valid_1` = 0, copy all slot-1 fields into the hold buffer, increment `perf_split_cnt`, go to `HOLD`.
  - No accept and no stall: clear both `out_valid` bits.
- FSM state `HOLD`:
  - `in_ready` = 0.
  - When !`ex_stall`: issue the held instruction in slot 0 with `out_valid_1` = 0, then go to `EMPTY`.
- `ex_stall` = 1: every output register, the hold buffer and the state are frozen. `in_ready` = 0.
- `flush` = 1: both `out_valid` bits go to 0, the hold buffer is invalidated, state goes to `EMPTY`. `flush` has priority over `ex_stall` and over acceptance. `perf_split_cnt` is unaffected.
- When `out_valid_x` = 0, the other fields of that slot are don't-care. The bench checks them only when the slot is valid.
- `perf_split_cnt` saturates at all ones and never wraps.

## Timing
- Reset (asynchronous, while `rst_n` = 0):
  - state is `EMPTY`;
  - all `out_*` are 0;
  - `perf_split_cnt` is 0;
  - hold buffer is 0.
- `in_ready` is combinational from state, `ex_stall` and `flush`. It does not depend on `in_valid`.
- Latency:
  - Pair accepted at edge T: slot 0 is visible from T (after the edge) through the next edge.
  - Non-conflicting pair: slot 1 is visible in the same cycle as slot 0.
  - Split pair: slot 1 appears in output slot 0 one cycle later, or later under `ex_stall`.
- Throughput: one pair per cycle when nothing conflicts. A split costs exactly one accept bubble: the `HOLD` cycle.
- `ex_stall` asserted in `HOLD`: the held instruction waits, and slot 0 keeps showing the first instruction.
- `flush` in the same cycle as `in_valid`: nothing is accepted.
- `rst_n` deasserted mid-`HOLD`: the held instruction is lost and the block returns to the reset values.

## Structure
- Reuse `ALU_OP_WIDTH and `ALU_MUL from the shared Define.v.
- Add the following to Define.v:
  - `ISSUE_ST_EMPTY` and `ISSUE_ST_HOLD` state encodings (1 bit);
  - `REG_IDX_WIDTH` = 5.
- One sub-module, `issue_conflict`: a purely combinational hazard check that takes both slots' flags and indices and produces a single `conflict` bit. It is reused by the bench's reference model.
- The hold buffer and output registers live in `issue_pair` itself. No FIFO instance.

## Test plan
- Pair of two ADDs, with rd 3 and 4 and sources not overlapping, no stall: both valid the next cycle, and `perf_split_cnt` stays 0.
- Slot 0 is a load with rd 5, slot 1 an ADD: cycle 1 shows `out_valid_0` = 1 and `out_valid_1` = 0; cycle 2 shows the ADD in slot 0. `in_ready` = 0 in cycle 1, and `perf_split_cnt` = 1.
- RAW: slot 0 writes x7 and slot 1 reads x7 → split. Repeat with rd = x0 → no split.
- Split pair with `ex_stall` held for 3 cycles in `HOLD`: outputs frozen, then the held instruction issues exactly once after the stall drops.
- `flush` asserted while in `HOLD`: next cycle both valids are 0, `in_ready` = 1, and a new pair is accepted normally.
- Force 2^`PERF_W` + 5 splits (`PERF_W` = 4): `perf_split_cnt` holds at 15.
